// File: rtl/m_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// number of bytes that make up one 32-bit stream word.
package m_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_W          = $clog2(BYTES_PER_WORD);

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_WR,
        ST_SUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/m_word_asm.sv
// Little-endian word assembler: collects four bytes into a 32-bit word and
// pulses w_last combinationally on the strobe that delivers the 4th byte.
module m_word_asm
    import m_loader_pkg::*;
(
    input  logic        w_clk,
    input  logic        w_rst_n,
    input  logic        w_strobe,
    input  logic [7:0]  w_data,
    input  logic        w_clear,
    output logic [31:0] w_word,
    output logic        w_last
);

    logic [CNT_W-1:0] r_cnt;
    logic [23:0]      r_lo;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
            r_lo  <= '0;
        end else if (w_clear) begin
            r_cnt <= '0;
            r_lo  <= '0;
        end else if (w_strobe) begin
            r_cnt <= r_cnt + 1'b1;
            for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_lo[8*k +: 8] <= w_data;
                end
            end
        end
    end

    // The top byte is never stored: the word is consumed on the same edge
    // that delivers it, so it is taken straight from the input.
    assign w_word = {w_data, r_lo};
    assign w_last = w_strobe & (r_cnt == CNT_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/m_loader.sv
// Program loader: parses a length/data/checksum byte stream, writes the
// words into instruction memory and enables the core once verified.
module m_loader
    import m_loader_pkg::*;
#(
    parameter int MAX_WORDS = 4096,
    parameter int ADDR_W    = 12
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_rx_valid,
    input  logic [7:0]        w_rx_data,
    output logic              w_rx_ready,
    output logic              w_mem_we,
    output logic [ADDR_W-1:0] w_mem_addr,
    output logic [31:0]       w_mem_din,
    output logic              w_ce,
    output logic              w_busy,
    output logic              w_err,
    output logic [ADDR_W:0]   w_nwords
);

    state_t          r_state;
    state_t          w_state_next;
    logic            w_xfer;
    logic            w_clear;
    logic [31:0]     w_word;
    logic            w_last;
    logic            w_last_word;
    logic [ADDR_W:0] w_idx_inc;

    logic [ADDR_W:0] r_idx;
    logic [ADDR_W:0] r_len;
    logic [31:0]     r_sum;
    logic [31:0]     r_din;
    logic            r_we;
    logic            r_ce;
    logic            r_err;
    logic            r_busy;

    assign w_rx_ready = (r_state == ST_LEN) || (r_state == ST_DATA) || (r_state == ST_SUM);
    assign w_xfer     = w_rx_valid & w_rx_ready;
    assign w_clear    = (r_state == ST_WR) || (r_state == ST_DONE) || (r_state == ST_ERR);
    assign w_idx_inc  = r_idx + {{ADDR_W{1'b0}}, 1'b1};
    assign w_last_word = (w_idx_inc == r_len);

    m_word_asm u_word_asm (
        .w_clk    (w_clk),
        .w_rst_n  (w_rst_n),
        .w_strobe (w_xfer),
        .w_data   (w_rx_data),
        .w_clear  (w_clear),
        .w_word   (w_word),
        .w_last   (w_last)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_LEN: begin
                if (w_last) begin
                    if (w_word > 32'(MAX_WORDS)) begin
                        w_state_next = ST_ERR;
                    end else if (w_word == 32'd0) begin
                        w_state_next = ST_SUM;
                    end else begin
                        w_state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (w_last) begin
                    w_state_next = ST_WR;
                end
            end
            ST_WR: begin
                w_state_next = w_last_word ? ST_SUM : ST_DATA;
            end
            ST_SUM: begin
                if (w_last) begin
                    w_state_next = (w_word == r_sum) ? ST_DONE : ST_ERR;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_LEN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_idx  <= '0;
            r_len  <= '0;
            r_sum  <= '0;
            r_din  <= '0;
            r_we   <= 1'b0;
            r_ce   <= 1'b0;
            r_err  <= 1'b0;
            r_busy <= 1'b0;
        end else begin
            // Write strobe is registered so it lines up with the WR state.
            r_we <= (w_state_next == ST_WR);
            if ((r_state == ST_LEN) && w_last) begin
                r_len <= w_word[ADDR_W:0];
            end
            if ((r_state == ST_DATA) && w_last) begin
                r_din <= w_word;
            end
            if (r_state == ST_WR) begin
                r_sum <= r_sum + r_din;
                r_idx <= w_idx_inc;
            end
            if (w_state_next == ST_DONE) begin
                r_ce <= 1'b1;
            end
            if (w_state_next == ST_ERR) begin
                r_err <= 1'b1;
            end
            if ((w_state_next == ST_DONE) || (w_state_next == ST_ERR)) begin
                r_busy <= 1'b0;
            end else if (w_xfer) begin
                r_busy <= 1'b1;
            end
        end
    end

    assign w_mem_we   = r_we;
    assign w_mem_addr = r_idx[ADDR_W-1:0];
    assign w_mem_din  = r_din;
    assign w_ce       = r_ce;
    assign w_err      = r_err;
    assign w_busy     = r_busy;
    assign w_nwords   = r_idx;

endmodule
